rollback_fifo: RTL and testbench
================================

Name: rollback_fifo

Overview:
- Parametrised packet FIFO with independent transactional rollback on the write and read sides. It is built on a register array and sits between the USB and Ethernet packet engines.
- The writer streams a packet in, then commits it or aborts it. Aborted data never becomes visible to the reader.
- The reader streams a packet out, then releases it or retries it. Retried data is replayed from the last release point.
- Full/empty use (ADDR_BITS+1)-bit pointers, so all DEPTH = 2^ADDR_BITS entries are usable.

Parameters:
DATA_WIDTH, 8, width of each stored word
ADDR_BITS, 4, log2 of depth; DEPTH = 2^ADDR_BITS
WR_ROLLBACK_EN, 1, 0 = every accepted write is implicitly committed; wr_commit and wr_abort are ignored
RD_ROLLBACK_EN, 1, 0 = every accepted read is implicitly released; rd_commit and rd_retry are ignored

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; one clock; reset is synchronous and active-high
clear  in  1  synchronous flush, same effect as rst
wr_en  in  1  write request
wr_data  in  DATA_WIDTH  write word
wr_commit  in  1  make all writes up to and including this cycle visible to the reader
wr_abort  in  1  discard all uncommitted writes
rd_en  in  1  read request (pop)
rd_commit  in  1  release all reads up to and including this cycle; frees their space
rd_retry  in  1  rewind the read pointer to the last release point
rd_data  out  DATA_WIDTH  show-ahead word at the read pointer
full  out  1  no free slot for the writer
empty  out  1  no committed unread word for the reader
wr_count  out  ADDR_BITS+1  slots held (wr_ptr - rd_cmt)
rd_avail  out  ADDR_BITS+1  committed unread words (wr_cmt - rd_ptr)
wr_overflow  out  1  registered 1-cycle pulse: wr_en was asserted while full
rd_underflow  out  1  registered 1-cycle pulse: rd_en was asserted while empty

Behaviour:
- State: four (ADDR_BITS+1)-bit pointers (wr_ptr, wr_cmt, rd_ptr, rd_cmt) and a DEPTH x DATA_WIDTH array. All arithmetic is modulo 2^(ADDR_BITS+1). The array is indexed by pointer[ADDR_BITS-1:0].
- rst or clear: all pointers 0, wr_overflow=0, rd_underflow=0 the next cycle. Outputs then read full=0, empty=1, wr_count=0, rd_avail=0. Array contents are don't-care. rst/clear override every other input in that cycle, including mid-packet.
- full = (wr_ptr - rd_cmt == DEPTH). empty = (rd_ptr == wr_cmt). Both are combinational from the registers.
- Write accepted iff wr_en && !full: mem[wr_ptr] <= wr_data; wr_ptr += 1.
- wr_en && full: no state change; wr_overflow=1 the next cycle.
- wr_commit: wr_cmt <= wr_ptr, or wr_ptr+1 if a write is accepted that cycle. Data becomes visible to the reader (empty/rd_avail) the next cycle.
- wr_abort: wr_ptr <= wr_cmt. Abort beats commit and beats any same-cycle write; that write is dropped and no overflow is flagged.
- Read accepted iff rd_en && !empty: rd_ptr += 1. rd_data is mem[rd_ptr], combinational, valid whenever !empty, 0-cycle latency.
- rd_en && empty: no state change; rd_underflow=1 the next cycle.
- rd_commit: rd_cmt <= rd_ptr, or rd_ptr+1 if a read is accepted that cycle. Freed space affects full/wr_count the next cycle.
- rd_retry: rd_ptr <= rd_cmt. Retry beats commit and beats any same-cycle read.
- Same-cycle write and read: both are accepted if their own conditions hold, evaluated on current-cycle full/empty. There is no bypass; an entry being freed this cycle cannot be written this cycle.
- WR_ROLLBACK_EN=0: wr_cmt tracks wr_ptr (committed on every accepted write).
- RD_ROLLBACK_EN=0: rd_cmt tracks rd_ptr.
- With both parameters 0 the block is a plain FIFO.
- Commit or abort with nothing pending is a legal no-op. Wrap-around is handled by pointer modulo arithmetic; no special case.
- Invariant: rd_cmt <= rd_ptr <= wr_cmt <= wr_ptr, all in modular distance, and wr_ptr - rd_cmt <= DEPTH.

Test Plan:
(DATA_WIDTH=8, ADDR_BITS=2, DEPTH=4, both rollback modes on unless noted)
1. Reset, write 0xA1,0xA2 without commit -> empty=1, rd_avail=0, wr_count=2. Assert wr_commit -> next cycle empty=0, rd_data=0xA1, rd_avail=2.
2. Commit 0x11,0x22; write 0x33,0x44; wr_abort -> wr_count=2. Write 0x55 and commit; read 3 words -> 0x11,0x22,0x55.
3. Commit 4 words -> full=1, wr_count=4. wr_en with 0x99 -> wr_overflow pulses 1 cycle, contents unchanged. Read 2 without commit -> full stays 1. rd_commit -> next cycle full=0, wr_count=2.
4. Commit 0x10,0x20,0x30; read 2 (0x10,0x20); rd_retry -> rd_data=0x10, rd_avail=3. Read 1 with same-cycle rd_commit -> rd_avail=2, rd_data=0x20.
5. Wrap: commit/read/release 3 words, then commit 4 more 0xC0..0xC3 -> full=1. Read all 4 back in order 0xC0..0xC3; then empty=1, and rd_en -> rd_underflow pulses.
6. WR_ROLLBACK_EN=0, RD_ROLLBACK_EN=0: write 0x5A -> rd_data=0x5A the next cycle. Assert wr_abort and rd_retry -> no effect. rst mid-stream -> full=0, empty=1, counts 0.

Source files
------------

// File: rtl/rollback_fifo_if.sv
// Packet FIFO handshake bundle: writer/reader strobes, data and status.
// The FIFO connects through the slave modport; the packet engine uses master.
interface rollback_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 4
);
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_commit;
    logic                  wr_abort;
    logic                  rd_en;
    logic                  rd_commit;
    logic                  rd_retry;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_BITS:0]    wr_count;
    logic [ADDR_BITS:0]    rd_avail;
    logic                  wr_overflow;
    logic                  rd_underflow;

    modport master (
        output wr_en, wr_data, wr_commit, wr_abort, rd_en, rd_commit, rd_retry,
        input  rd_data, full, empty, wr_count, rd_avail, wr_overflow, rd_underflow
    );

    modport slave (
        input  wr_en, wr_data, wr_commit, wr_abort, rd_en, rd_commit, rd_retry,
        output rd_data, full, empty, wr_count, rd_avail, wr_overflow, rd_underflow
    );
endinterface

// File: rtl/rollback_fifo.sv
// Register-array packet FIFO with commit/abort on the write side and
// release/retry on the read side, using (ADDR_BITS+1)-bit wrapping pointers.
module rollback_fifo #(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_BITS      = 4,
    parameter bit          WR_ROLLBACK_EN = 1'b1,
    parameter bit          RD_ROLLBACK_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    rollback_fifo_if.slave   bus
);
    localparam int unsigned Depth = 1 << ADDR_BITS;

    typedef logic [ADDR_BITS:0] ptr_t;

    logic [DATA_WIDTH-1:0] mem_q [Depth];

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t wr_cmt_q, wr_cmt_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    ptr_t rd_cmt_q, rd_cmt_d;
    logic wr_overflow_q, wr_overflow_d;
    logic rd_underflow_q, rd_underflow_d;

    logic full, empty;
    logic wr_abort_eff, wr_commit_eff, rd_retry_eff, rd_commit_eff;
    logic wr_accept, rd_accept;
    ptr_t wr_ptr_inc, rd_ptr_inc;

    assign full  = ptr_t'(wr_ptr_q - rd_cmt_q) == ptr_t'(Depth);
    assign empty = rd_ptr_q == wr_cmt_q;

    // With rollback disabled every accepted transfer is committed immediately.
    assign wr_abort_eff  = WR_ROLLBACK_EN && bus.wr_abort;
    assign wr_commit_eff = WR_ROLLBACK_EN ? bus.wr_commit : 1'b1;
    assign rd_retry_eff  = RD_ROLLBACK_EN && bus.rd_retry;
    assign rd_commit_eff = RD_ROLLBACK_EN ? bus.rd_commit : 1'b1;

    assign wr_accept  = bus.wr_en && !full && !wr_abort_eff;
    assign rd_accept  = bus.rd_en && !empty && !rd_retry_eff;
    assign wr_ptr_inc = wr_ptr_q + ptr_t'(wr_accept);
    assign rd_ptr_inc = rd_ptr_q + ptr_t'(rd_accept);

    always_comb begin
        wr_ptr_d       = wr_abort_eff ? wr_cmt_q : wr_ptr_inc;
        wr_cmt_d       = wr_cmt_q;
        rd_ptr_d       = rd_retry_eff ? rd_cmt_q : rd_ptr_inc;
        rd_cmt_d       = rd_cmt_q;
        wr_overflow_d  = bus.wr_en && full && !wr_abort_eff;
        rd_underflow_d = bus.rd_en && empty;
        if (!wr_abort_eff && wr_commit_eff) begin
            wr_cmt_d = wr_ptr_inc;
        end
        if (!rd_retry_eff && rd_commit_eff) begin
            rd_cmt_d = rd_ptr_inc;
        end
        if (rst || clear) begin
            wr_ptr_d       = '0;
            wr_cmt_d       = '0;
            rd_ptr_d       = '0;
            rd_cmt_d       = '0;
            wr_overflow_d  = 1'b0;
            rd_underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        wr_ptr_q       <= wr_ptr_d;
        wr_cmt_q       <= wr_cmt_d;
        rd_ptr_q       <= rd_ptr_d;
        rd_cmt_q       <= rd_cmt_d;
        wr_overflow_q  <= wr_overflow_d;
        rd_underflow_q <= rd_underflow_d;
    end

    // Array contents are don't-care after reset, so storage is not reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem_q[wr_ptr_q[ADDR_BITS-1:0]] <= bus.wr_data;
        end
    end

    assign bus.rd_data      = mem_q[rd_ptr_q[ADDR_BITS-1:0]];
    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.wr_count     = wr_ptr_q - rd_cmt_q;
    assign bus.rd_avail     = wr_cmt_q - rd_ptr_q;
    assign bus.wr_overflow  = wr_overflow_q;
    assign bus.rd_underflow = rd_underflow_q;
endmodule

// File: tb/tb_rollback_fifo.sv
// Directed bench: a rollback-enabled instance and a plain-FIFO instance,
// both DEPTH=4, checked against hand-computed values.
module tb_rollback_fifo;
    logic clk = 1'b0;
    logic rst;
    logic clear;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    rollback_fifo_if #(.DATA_WIDTH(8), .ADDR_BITS(2)) bus_a ();
    rollback_fifo_if #(.DATA_WIDTH(8), .ADDR_BITS(2)) bus_b ();

    rollback_fifo #(
        .DATA_WIDTH(8), .ADDR_BITS(2), .WR_ROLLBACK_EN(1'b1), .RD_ROLLBACK_EN(1'b1)
    ) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .bus(bus_a.slave)
    );

    rollback_fifo #(
        .DATA_WIDTH(8), .ADDR_BITS(2), .WR_ROLLBACK_EN(1'b0), .RD_ROLLBACK_EN(1'b0)
    ) dut_b (
        .clk(clk), .rst(rst), .clear(1'b0), .bus(bus_b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        clear = 1'b0;
        rst   = 1'b0;
        bus_a.wr_en = 1'b0; bus_a.wr_data = '0; bus_a.wr_commit = 1'b0; bus_a.wr_abort = 1'b0;
        bus_a.rd_en = 1'b0; bus_a.rd_commit = 1'b0; bus_a.rd_retry = 1'b0;
        bus_b.wr_en = 1'b0; bus_b.wr_data = '0; bus_b.wr_commit = 1'b0; bus_b.wr_abort = 1'b0;
        bus_b.rd_en = 1'b0; bus_b.rd_commit = 1'b0; bus_b.rd_retry = 1'b0;
    endtask

    // Apply the currently driven inputs for one edge, then return to idle.
    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    task automatic push(input logic [7:0] d, input logic cmt);
        bus_a.wr_en = 1'b1; bus_a.wr_data = d; bus_a.wr_commit = cmt;
        step();
    endtask

    task automatic pop(input string tag, input logic [7:0] exp, input logic cmt);
        chk(tag, {24'd0, bus_a.rd_data}, {24'd0, exp});
        bus_a.rd_en = 1'b1; bus_a.rd_commit = cmt;
        step();
    endtask

    task automatic flush();
        clear = 1'b1;
        step();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        step();
        chk("rst_full",     bus_a.full,     0);
        chk("rst_empty",    bus_a.empty,    1);
        chk("rst_wr_count", bus_a.wr_count, 0);
        chk("rst_rd_avail", bus_a.rd_avail, 0);
        chk("rst_ovf",      bus_a.wr_overflow, 0);

        // 1: uncommitted writes stay invisible until wr_commit.
        push(8'hA1, 0);
        push(8'hA2, 0);
        chk("t1_empty_pre",  bus_a.empty,    1);
        chk("t1_avail_pre",  bus_a.rd_avail, 0);
        chk("t1_count_pre",  bus_a.wr_count, 2);
        bus_a.wr_commit = 1'b1;
        step();
        chk("t1_empty_post", bus_a.empty,    0);
        chk("t1_rd_data",    bus_a.rd_data,  8'hA1);
        chk("t1_avail_post", bus_a.rd_avail, 2);
        flush();
        chk("clr_empty",     bus_a.empty,    1);
        chk("clr_count",     bus_a.wr_count, 0);

        // 2: abort drops uncommitted words and a same-cycle write.
        push(8'h11, 0);
        push(8'h22, 1);
        push(8'h33, 0);
        push(8'h44, 0);
        bus_a.wr_abort = 1'b1; bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h77; bus_a.wr_commit = 1'b1;
        step();
        chk("t2_count_abort", bus_a.wr_count, 2);
        chk("t2_avail_abort", bus_a.rd_avail, 2);
        push(8'h55, 1);
        pop("t2_rd0", 8'h11, 0);
        pop("t2_rd1", 8'h22, 0);
        pop("t2_rd2", 8'h55, 1);
        chk("t2_empty", bus_a.empty,    1);
        chk("t2_count", bus_a.wr_count, 0);

        // 3: full, overflow pulse, space freed only by rd_commit.
        push(8'h01, 0);
        push(8'h02, 0);
        push(8'h03, 0);
        push(8'h04, 1);
        chk("t3_full",  bus_a.full,     1);
        chk("t3_count", bus_a.wr_count, 4);
        push(8'h99, 0);
        chk("t3_ovf_hi",  bus_a.wr_overflow, 1);
        step();
        chk("t3_ovf_lo",  bus_a.wr_overflow, 0);
        chk("t3_count2",  bus_a.wr_count,    4);
        pop("t3_rd0", 8'h01, 0);
        pop("t3_rd1", 8'h02, 0);
        chk("t3_full_held", bus_a.full, 1);
        bus_a.rd_commit = 1'b1;
        step();
        chk("t3_full_rel",  bus_a.full,     0);
        chk("t3_count_rel", bus_a.wr_count, 2);
        chk("t3_rd_next",   bus_a.rd_data,  8'h03);
        flush();

        // 4: retry replays from the release point; read+commit releases it.
        push(8'h10, 0);
        push(8'h20, 0);
        push(8'h30, 1);
        pop("t4_rd0", 8'h10, 0);
        pop("t4_rd1", 8'h20, 0);
        bus_a.rd_retry = 1'b1; bus_a.rd_en = 1'b1; bus_a.rd_commit = 1'b1;
        step();
        chk("t4_retry_data",  bus_a.rd_data,  8'h10);
        chk("t4_retry_avail", bus_a.rd_avail, 3);
        pop("t4_rd_again", 8'h10, 1);
        chk("t4_avail", bus_a.rd_avail, 2);
        chk("t4_data",  bus_a.rd_data,  8'h20);
        chk("t4_count", bus_a.wr_count, 2);
        flush();

        // 5: pointers start at 3, so the next four words wrap the array.
        push(8'h01, 0);
        push(8'h02, 0);
        push(8'h03, 1);
        pop("t5_pre0", 8'h01, 0);
        pop("t5_pre1", 8'h02, 0);
        pop("t5_pre2", 8'h03, 1);
        push(8'hC0, 0);
        push(8'hC1, 0);
        push(8'hC2, 0);
        push(8'hC3, 1);
        chk("t5_full", bus_a.full, 1);
        pop("t5_rd0", 8'hC0, 0);
        pop("t5_rd1", 8'hC1, 0);
        pop("t5_rd2", 8'hC2, 0);
        pop("t5_rd3", 8'hC3, 1);
        chk("t5_empty", bus_a.empty,    1);
        chk("t5_count", bus_a.wr_count, 0);
        bus_a.rd_en = 1'b1;
        step();
        chk("t5_udf_hi",  bus_a.rd_underflow, 1);
        chk("t5_rd_avail", bus_a.rd_avail,    0);
        step();
        chk("t5_udf_lo",  bus_a.rd_underflow, 0);

        // 6: plain FIFO ignores abort/retry; rst clears mid-stream.
        bus_b.wr_en = 1'b1; bus_b.wr_data = 8'h5A;
        step();
        chk("t6_data",  bus_b.rd_data,  8'h5A);
        chk("t6_empty", bus_b.empty,    0);
        chk("t6_avail", bus_b.rd_avail, 1);
        bus_b.wr_abort = 1'b1; bus_b.rd_retry = 1'b1;
        step();
        chk("t6_abort_avail", bus_b.rd_avail, 1);
        chk("t6_abort_count", bus_b.wr_count, 1);
        bus_b.rd_en = 1'b1;
        step();
        chk("t6_pop_empty", bus_b.empty,    1);
        chk("t6_pop_count", bus_b.wr_count, 0);
        bus_b.rd_retry = 1'b1;
        step();
        chk("t6_retry_empty", bus_b.empty, 1);
        bus_b.wr_en = 1'b1; bus_b.wr_data = 8'h6B;
        step();
        bus_b.wr_en = 1'b1; bus_b.wr_data = 8'h7C;
        step();
        chk("t6_count2", bus_b.wr_count, 2);
        rst = 1'b1; bus_b.wr_en = 1'b1; bus_b.wr_data = 8'h8D;
        step();
        chk("t6_rst_full",  bus_b.full,     0);
        chk("t6_rst_empty", bus_b.empty,    1);
        chk("t6_rst_count", bus_b.wr_count, 0);
        chk("t6_rst_avail", bus_b.rd_avail, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
